// File: rtl/aes_queue_pkg.sv
// aes_queue_pkg: shared encodings, defaults and AES byte arithmetic
package aes_queue_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CTR_W = 32;
  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CTR = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_READY, ST_LOAD, ST_WAIT, ST_PUSH} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (b^254 by repeated squaring) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_cipher_top.sv
// aes_cipher_top: iterative AES-128 encryption core, one round per cycle
module aes_cipher_top
  import aes_queue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  output logic         done,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);
  logic [127:0] st_q;
  logic [127:0] rk_q;
  logic [127:0] nrk;
  logic [7:0]   rc_q;
  logic [3:0]   rnd_q;
  logic         done_q;
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   a [4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = b[4*((c+r)%4)+r];
      o[127-32*c -: 32] = last ? {a[0], a[1], a[2], a[3]} :
        {xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3],
         a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3],
         a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3],
         xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3])};
    end
    return o ^ rk;
  endfunction
  assign nrk = next_key(rk_q, rc_q);
  assign done = done_q;
  assign text_out = st_q;
  // ld applies the whitening key; then ten rounds run back to back and done pulses once
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q <= '0;
      rk_q <= '0;
      rc_q <= '0;
      rnd_q <= '0;
      done_q <= 1'b0;
    end else if (ld) begin
      st_q <= text_in ^ key;
      rk_q <= key;
      rc_q <= 8'h01;
      rnd_q <= 4'd1;
      done_q <= 1'b0;
    end else if (rnd_q != 4'd0) begin
      st_q <= aes_round(st_q, nrk, rnd_q == 4'd10);
      rk_q <= nrk;
      rc_q <= xtime(rc_q);
      rnd_q <= (rnd_q == 4'd10) ? 4'd0 : rnd_q + 4'd1;
      done_q <= rnd_q == 4'd10;
    end else begin
      done_q <= 1'b0;
    end
endmodule

// File: rtl/aes_out_fifo.sv
// aes_out_fifo: first-word-fall-through FIFO with wrap-bit pointers
module aes_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  assign valid_o = wr_q != rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o = valid_o ? mem_q[rd_q[AW-1:0]] : '0;
  // storage needs no reset: the head is masked to zero while empty
  always_ff @(posedge clk)
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  // pointers advance independently so a simultaneous push and pop keeps occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && valid_o) rd_q <= rd_q + 1'b1;
    end
endmodule

// File: rtl/aes_cipher_queue.sv
// aes_cipher_queue: ECB/CTR session controller around the AES core with an output FIFO
module aes_cipher_queue
  import aes_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CTR_W = DEFAULT_CTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         mode,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);
  state_e       state_q;
  logic [127:0] key_q;
  logic [127:0] ctr_q;
  logic [127:0] ctr_d;
  logic [127:0] data_q;
  logic         mode_q;
  logic         fifo_full;
  logic         core_done;
  logic [127:0] core_out;
  logic [127:0] push_data;
  assign ctr_d = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
  assign push_data = (mode_q == MODE_CTR) ? core_out ^ data_q : core_out;
  // blocks in flight only exist outside READY, so FIFO space alone is the credit here
  assign in_ready = (state_q == ST_READY) && !fifo_full && !start;
  assign busy = (state_q != ST_IDLE) || out_valid;
  // session FSM: latch parameters on start, walk each block through load, wait and push
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q <= '0;
      ctr_q <= '0;
      data_q <= '0;
      mode_q <= MODE_ECB;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          key_q <= key;
          ctr_q <= iv;
          mode_q <= mode;
          state_q <= ST_READY;
        end
        ST_READY: if (start) state_q <= ST_IDLE;
          else if (in_valid && in_ready) begin
            data_q <= in_data;
            state_q <= ST_LOAD;
          end
        ST_LOAD: state_q <= ST_WAIT;
        ST_WAIT: if (core_done) state_q <= ST_PUSH;
        ST_PUSH: begin
          if (mode_q == MODE_CTR) ctr_q <= ctr_d;
          state_q <= ST_READY;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  aes_cipher_top u_core (
    .clk      (clk),
    .rst      (rst),
    .ld       (state_q == ST_LOAD),
    .done     (core_done),
    .key      (key_q),
    .text_in  ((mode_q == MODE_CTR) ? ctr_q : data_q),
    .text_out (core_out)
  );
  aes_out_fifo #(.DEPTH(DEPTH), .W(128)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (state_q == ST_PUSH),
    .data_i  (push_data),
    .pop_i   (out_valid && out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .full_o  (fifo_full)
  );
endmodule

// File: tb/tb_aes_cipher_queue.sv
// tb_aes_cipher_queue: randomized and directed checks against a software AES queue model
module tb_aes_cipher_queue;
  localparam int DEPTH = 4;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FP = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FC = 128'h3925841d02dc09fbdc118597196a0b32;
  logic clk = 0;
  logic rst = 0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic mode = 0;
  logic start = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [127:0] in_data = '0;
  logic out_valid;
  logic out_ready = 0;
  logic [127:0] out_data;
  logic busy;
  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int accepts = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_pop = '0;
  logic [127:0] m_key = '0;
  logic [127:0] m_ctr = '0;
  logic m_mode = 0;
  logic m_active = 0;
  logic pv = 0;
  logic pr = 0;
  logic [127:0] pd = '0;
  logic [7:0] sb [256];

  aes_cipher_queue #(.DEPTH(DEPTH), .CTR_W(32)) dut (
    .clk(clk), .rst(rst), .key(key), .iv(iv), .mode(mode), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, x;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = p[127-8*i -: 8] ^ w[i];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        x = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[x];
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i%4)) % 16]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
          s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one compare process: every cycle, against the queue model
  always @(negedge clk) begin
    if (rst) begin
      if (!m_active) check("idle_in_ready", 128'(in_ready), 128'd0);
      if (in_ready) check("credit", 128'(exp_q.size() < DEPTH), 128'd1);
      if (exp_q.size() != 0) check("busy_queued", 128'(busy), 128'd1);
      if (!m_active && exp_q.size() == 0) check("busy_idle", 128'(busy), 128'd0);
      if (pv && !pr) begin
        check("hold_valid", 128'(out_valid), 128'd1);
        check("hold_data", out_data, pd);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        last_pop = out_data;
        pops++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(m_mode ? aes_model(m_key, m_ctr) ^ in_data : aes_model(m_key, in_data));
        if (m_mode) m_ctr[31:0] = m_ctr[31:0] + 32'd1;
        accepts++;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end else begin
      pv = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] v, input logic md);
    key = k;
    iv = v;
    mode = md;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    if (!m_active) begin
      m_key = k;
      m_ctr = v;
      m_mode = md;
    end
    m_active = !m_active;
  endtask

  task automatic session(input logic [127:0] k, input logic [127:0] v, input logic md);
    if (m_active) begin
      idle(16);
      do_start(k, v, md);
    end
    do_start(k, v, md);
  endtask

  task automatic send(input logic [127:0] d);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_data = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    @(posedge clk);
    #1 in_valid = 0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = $urandom_range(0, 1) == 1;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c63;
    logic [7:0] inv;
    logic [7:0] s;
    logic [127:0] v2;
    logic [127:0] d1;
    logic [127:0] d2;
    int lat;
    int a0;
    int p0;
    bit got;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sb[x] = s;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    rst = 1;
    check("model_kat_1", aes_model(K0, P0), C0);
    check("model_kat_2", aes_model(FK, FP), FC);
    // ECB known answer and empty-FIFO latency
    session(K0, '0, 1'b0);
    out_ready = 1;
    send(P0);
    lat = 0;
    got = 0;
    while (lat < 100 && !got) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    check("latency", 128'(lat), 128'd14);
    check("ecb_kat", out_data, C0);
    idle(1);
    // CTR counter wrap in the low 32 bits only
    v2 = {96'hf0e1d2c3b4a5968778695a4b, 32'hffffffff};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    session(FK, v2, 1'b1);
    send(d1);
    check("ctr_wrap_model", m_ctr, {v2[127:32], 32'h0});
    send(d2);
    drain();
    check("ctr_block2", last_pop, aes_model(FK, {v2[127:32], 32'h0}) ^ d2);
    // backpressure: exactly DEPTH accepted, one more after a single pop
    session({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
    out_ready = 0;
    a0 = accepts;
    in_valid = 1;
    for (int i = 0; i < 80; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      idle(1);
    end
    check("bp_accepts", 128'(accepts - a0), 128'd4);
    check("bp_in_ready", 128'(in_ready), 128'd0);
    out_ready = 1;
    idle(1);
    out_ready = 0;
    for (int i = 0; i < 40; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      idle(1);
    end
    in_valid = 0;
    check("bp_after_pop", 128'(accepts - a0), 128'd5);
    drain();
    // push and pop in the same cycle at occupancy 2
    out_ready = 0;
    send({$urandom, $urandom, $urandom, $urandom});
    send({$urandom, $urandom, $urandom, $urandom});
    idle(16);
    send({$urandom, $urandom, $urandom, $urandom});
    idle(12);
    out_ready = 1;
    idle(1);
    out_ready = 0;
    idle(4);
    p0 = pops;
    drain();
    check("simul_occupancy", 128'(pops - p0), 128'd2);
    // reset three cycles after ld with one block queued
    out_ready = 0;
    send({$urandom, $urandom, $urandom, $urandom});
    idle(16);
    send({$urandom, $urandom, $urandom, $urandom});
    idle(3);
    rst = 0;
    exp_q.delete();
    m_active = 0;
    #1;
    check("rst_wait_out_valid", 128'(out_valid), 128'd0);
    check("rst_wait_busy", 128'(busy), 128'd0);
    idle(2);
    rst = 1;
    idle(1);
    session(K0, '0, 1'b0);
    p0 = pops;
    out_ready = 1;
    send(P0);
    drain();
    idle(4);
    check("post_rst_count", 128'(pops - p0), 128'd1);
    check("post_rst_data", last_pop, C0);
    // restart with two blocks queued: old key drains, new key applies after
    session({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
    out_ready = 0;
    send({$urandom, $urandom, $urandom, $urandom});
    send({$urandom, $urandom, $urandom, $urandom});
    idle(16);
    do_start(FK, '0, 1'b0);
    do_start(FK, '0, 1'b0);
    send(FP);
    drain();
    check("restart_new_key", last_pop, FC);
    // randomized sessions
    for (int n = 0; n < 4; n++) begin
      session({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? 32'hfffffffe : $urandom},
              $urandom_range(0, 1) == 1);
      run_random(150);
      drain();
    end
    idle(16);
    do_start('0, '0, 1'b0);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
